mips_multi: RTL and testbench

Multicycle 32-bit MIPS core: the next generation after the single-cycle `mips`. It uses a single shared instruction/data memory port with a request/ready handshake, so memories may insert wait states. A state-machine controller sequences each instruction over 3–5 cycles. It sits under a top level beside one unified memory (ROM/SRAM behind an arbiter or a single RAM) and adds `and`, `or`, `slt`, an illegal-instruction trap and a retire strobe.

---
 rtl/mips_multi.sv | 164 ++++++++++++++++
 tb/tb_mips_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multi.sv
// Multicycle 32-bit MIPS core sharing one req/ready memory port for fetch and data.
// Optional feature macro: MIPS_MULTI_BNE_EN (decodes bne as an inverted-condition branch).
module mips_multi #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        memReq,
    output logic        memWriteEnable,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    input  logic        memReady,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap
);
    localparam int RW = $clog2(NREGS);
    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_J = 6'h02;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE,
        ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_q, ir, mdr, a, b, alu_out;
    logic [31:0] rf [NREGS];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sign_imm, rf_rs, rf_rt, alu_r, rf_wd;
    logic [4:0]  rf_wa;
    logic        rf_we, funct_ok, regs_ok, take;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sign_imm = {{16{ir[15]}}, ir[15:0]};
    assign rf_rs    = (rs == 5'd0) ? 32'd0 : rf[rs[RW-1:0]];
    assign rf_rt    = (rt == 5'd0) ? 32'd0 : rf[rt[RW-1:0]];
    assign funct_ok = funct inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    // j carries no register fields; everything else must name implemented registers
    assign regs_ok  = (op == OP_J) ||
                      (({27'b0, rs} < NREGS) && ({27'b0, rt} < NREGS) &&
                       (op != OP_R || {27'b0, rd} < NREGS));
    assign take     = (a == b) ^ (op == OP_BNE);

    always_comb begin
        alu_r = a + b;
        case (funct)
            6'd34:   alu_r = a - b;
            6'd36:   alu_r = a & b;
            6'd37:   alu_r = a | b;
            6'd42:   alu_r = {31'b0, $signed(a) < $signed(b)};
            default: alu_r = a + b;
        endcase
    end

    always_comb begin
        state_next     = state;
        memReq         = 1'b0;
        memWriteEnable = 1'b0;
        retire         = 1'b0;
        trap           = 1'b0;
        memAddress     = (state == FETCH) ? pc_q : alu_out;
        memWriteData   = b;
        pc             = (state == FETCH) ? pc_q : pc_q - 32'd4;
        rf_we          = 1'b0;
        rf_wa          = rt;
        rf_wd          = alu_out;
        case (state)
            FETCH: begin
                memReq = 1'b1;
                if (memReady) state_next = DECODE;
            end
            DECODE: begin
                state_next = TRAP;
                if (regs_ok) begin
                    case (op)
                        OP_R:         if (funct_ok) state_next = RTYPE;
                        OP_LW, OP_SW: state_next = MEMADR;
                        OP_BEQ:       state_next = BRANCH;
`ifdef MIPS_MULTI_BNE_EN
                        OP_BNE:       state_next = BRANCH;
`endif
                        OP_ADDI:      state_next = ADDIEX;
                        OP_J:         state_next = JUMP;
                        default:      state_next = TRAP;
                    endcase
                end
            end
            MEMADR: state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                memReq = 1'b1;
                if (memReady) state_next = MEMWB;
            end
            MEMWB: begin
                rf_we = 1'b1; rf_wd = mdr; retire = 1'b1; state_next = FETCH;
            end
            MEMWR: begin
                memReq = 1'b1; memWriteEnable = 1'b1;
                if (memReady) begin retire = 1'b1; state_next = FETCH; end
            end
            RTYPE:  state_next = ALUWB;
            ALUWB: begin
                rf_we = 1'b1; rf_wa = rd; retire = 1'b1; state_next = FETCH;
            end
            ADDIEX: state_next = ADDIWB;
            ADDIWB: begin
                rf_we = 1'b1; retire = 1'b1; state_next = FETCH;
            end
            BRANCH, JUMP: begin
                retire = 1'b1; state_next = FETCH;
            end
            TRAP:    trap = 1'b1;
            default: state_next = TRAP;
        endcase
        // reset masks everything so an in-flight access is abandoned at once
        if (reset) begin
            memReq = 1'b0; memWriteEnable = 1'b0; retire = 1'b0; trap = 1'b0; rf_we = 1'b0;
            memAddress = RESET_PC; memWriteData = 32'd0; pc = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            a       <= 32'd0;
            b       <= 32'd0;
            alu_out <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                FETCH: if (memReady) begin
                    ir   <= memReadData;
                    pc_q <= pc_q + 32'd4;
                end
                DECODE: begin
                    a       <= rf_rs;
                    b       <= rf_rt;
                    alu_out <= pc_q + (sign_imm << 2);
                end
                MEMADR, ADDIEX: alu_out <= a + sign_imm;
                MEMRD:  if (memReady) mdr <= memReadData;
                RTYPE:  alu_out <= alu_r;
                BRANCH: if (take) pc_q <= alu_out;
                JUMP:   pc_q <= {pc_q[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && rf_wa != 5'd0) rf[rf_wa[RW-1:0]] <= rf_wd;
    end
endmodule

// File: tb/tb_mips_multi.sv
// Scoreboard bench for mips_multi: expected retires/writes queued per program, checked as they occur.
module tb_mips_multi;
    localparam logic [31:0] RPC   = 32'h100;
    localparam logic [31:0] TRAPW = 32'hFC00_0000;

    logic        clk = 1'b0, reset = 1'b1;
    logic        memReq, memWriteEnable, memReady, retire, trap;
    logic [31:0] memAddress, memWriteData, memReadData, pc;

    always #5 clk = ~clk;

    mips_multi #(.RESET_PC(RPC), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .memReq(memReq), .memWriteEnable(memWriteEnable),
        .memAddress(memAddress), .memWriteData(memWriteData), .memReadData(memReadData),
        .memReady(memReady), .pc(pc), .retire(retire), .trap(trap)
    );

    typedef struct { logic [31:0] pc; int cyc; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int hold; } wr_t;
    ret_t        rq[$];
    wr_t         wq[$];
    logic [31:0] prog[$];
    int          total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // unified memory: program ROM at 0x100.., data RAM below 0x100, programmable wait states
    logic [31:0] rom  [0:255];
    logic [31:0] dram [0:63];
    int          waits = 0, wcnt = 0;
    logic        mem_clr = 1'b0;

    assign memReady    = memReq && (wcnt >= waits);
    assign memReadData = (memAddress < 32'h100) ? dram[memAddress[7:2]] : rom[memAddress[9:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) dram[i] <= TRAPW;
        end else if (memReq && memReady && memWriteEnable && memAddress < 32'h100) begin
            dram[memAddress[7:2]] <= memWriteData;
        end
        wcnt <= (memReq && !memReady) ? wcnt + 1 : 0;
    end

    int cnt = 0, we_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            cnt = 0; we_cnt = 0;
        end else begin
            ret_t r;
            wr_t  w;
            cnt++;
            if (memWriteEnable) we_cnt++;
            if (retire) begin
                chk("ret_pending", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    chk("ret_pc", pc, r.pc);
                    chk("ret_cyc", 32'(cnt), 32'(r.cyc));
                end
                cnt = 0;
            end
            if (memReq && memReady && memWriteEnable) begin
                chk("wr_pending", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("wr_addr", memAddress, w.addr);
                    chk("wr_data", memWriteData, w.data);
                    chk("wr_hold", 32'(we_cnt), 32'(w.hold));
                end
                we_cnt = 0;
            end
        end
    end

    task automatic exp_ret(input logic [31:0] p, input int c);
        rq.push_back(ret_t'{p, c});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input int h);
        wq.push_back(wr_t'{a, d, h});
    endtask

    task automatic load();
        for (int i = 0; i < 256; i++) rom[i] = TRAPW;
        foreach (prog[i]) rom[64 + i] = prog[i];
    endtask

    task automatic rst_assert(input bit clr);
        @(negedge clk);
        reset = 1'b1;
        mem_clr = clr;
        @(posedge clk);
        #1 mem_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(memReq), 32'd0);
        chk("rst_we", 32'(memWriteEnable), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_addr", memAddress, RPC);
        chk("rst_wdata", memWriteData, 32'd0);
        chk("rst_pc", pc, RPC);
    endtask

    task automatic rst_release();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("fetch_req", 32'(memReq), 32'd1);
        chk("fetch_addr", memAddress, RPC);
        chk("fetch_pc", pc, RPC);
        chk("fetch_trap", 32'(trap), 32'd0);
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(rq.size() + wq.size()), 32'd0);
        rq.delete();
        wq.delete();
    endtask

    initial begin
        // ALU ops, each result stored to memory for observation
        rst_assert(1);
        prog = '{32'h20010005, 32'h2002FFFD,
                 32'h00221820, 32'hAC030000, 32'h00221822, 32'hAC030004,
                 32'h00221824, 32'hAC030008, 32'h00221825, 32'hAC03000C,
                 32'h0022182A, 32'hAC030010};
        load(); waits = 0;
        rst_release();
        for (int i = 0; i < 12; i++) exp_ret(RPC + 32'(4 * i), 4);
        exp_wr(32'd0, 32'd2, 1);
        exp_wr(32'd4, 32'd8, 1);
        exp_wr(32'd8, 32'd5, 1);
        exp_wr(32'd12, 32'hFFFF_FFFD, 1);
        exp_wr(32'd16, 32'd0, 1);
        run_drain(300);
        repeat (4) @(negedge clk);
        chk("alu_end_trap", 32'(trap), 32'd1);
        chk("alu_end_req", 32'(memReq), 32'd0);

        // memory with two wait states per access
        rst_assert(1);
        prog = '{32'h20010005, 32'hAC010008, 32'h8C040008, 32'hAC04000C};
        load(); waits = 2;
        rst_release();
        exp_ret(32'h100, 6); exp_ret(32'h104, 8); exp_ret(32'h108, 9); exp_ret(32'h10C, 8);
        exp_wr(32'd8, 32'd5, 3);
        exp_wr(32'd12, 32'd5, 3);
        run_drain(300);

        // beq not taken, then j back to 0x100
        rst_assert(0);
        prog = '{32'h20010005, 32'h10200005, 32'h08000040};
        load(); waits = 0;
        rst_release();
        for (int k = 0; k < 2; k++) begin
            exp_ret(32'h100, 4); exp_ret(32'h104, 3); exp_ret(32'h108, 3);
        end
        run_drain(200);
        @(negedge clk);
        chk("j_target", memAddress, 32'h100);

        // beq $1,$1,-1 self loop
        rst_assert(0);
        prog = '{32'h1021FFFF};
        load();
        rst_release();
        for (int k = 0; k < 5; k++) exp_ret(32'h100, 3);
        run_drain(200);

        // bne $1,$2,+2
        rst_assert(1);
        prog = '{32'h20010005, 32'h2002FFFD, 32'h14220002, TRAPW, TRAPW, 32'hAC010014};
        load();
        rst_release();
        exp_ret(32'h100, 4); exp_ret(32'h104, 4);
`ifdef MIPS_MULTI_BNE_EN
        exp_ret(32'h108, 3); exp_ret(32'h114, 4);
        exp_wr(32'd20, 32'd5, 1);
`endif
        run_drain(200);
        repeat (4) @(negedge clk);
        chk("bne_end_trap", 32'(trap), 32'd1);

        // illegal opcode traps after DECODE
        rst_assert(0);
        prog = '{TRAPW};
        load();
        rst_release();
        @(negedge clk);
        chk("trap_in_decode", 32'(trap), 32'd0);
        @(negedge clk);
        chk("trap_set", 32'(trap), 32'd1);
        chk("trap_req", 32'(memReq), 32'd0);
        repeat (3) @(negedge clk);
        chk("trap_sticky", 32'(trap), 32'd1);

        // reset during a waiting store abandons it
        rst_assert(1);
        prog = '{32'h20010005, 32'hAC010008};
        load(); waits = 3;
        rst_release();
        exp_ret(32'h100, 7);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (memWriteEnable) break;
        end
        chk("we_seen", 32'(memWriteEnable), 32'd1);
        rst_assert(0);
        rst_release();
        repeat (3) @(negedge clk);
        chk("no_write", dram[2], TRAPW);
        chk("ret_drained", 32'(rq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
